alu_arbiter: RTL and testbench

Shares the single 32-bit `ALU` between two requesters (e.g. the integer execute stage and the address/branch helper) using a valid/ready request channel and a valid/ready response channel per requester. It arbitrates round-robin, registers operands and op, lets the `ALU` evaluate for one cycle, and holds the result until the owning requester accepts it. It is one transaction at a time; no reordering is possible.

---
 rtl/alu_arbiter_pkg.sv | 44 ++++
 rtl/alu_arbiter_rr_arb2.sv | 18 +
 rtl/alu_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op codes, FSM states and
// the ALU evaluation function.
package alu_arbiter_pkg;

    localparam int unsigned AluWidth   = 32;
    localparam int unsigned ShAmtWidth = 5;

    typedef enum logic [2:0] {
        AluAdd  = 3'b000,
        AluSub  = 3'b001,
        AluAnd  = 3'b010,
        AluOr   = 3'b011,
        AluXor  = 3'b100,
        AluRsvd = 3'b101,
        AluSll  = 3'b110,
        AluSrl  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StResp = 2'b10
    } state_e;

    function automatic logic [AluWidth-1:0] alu_eval(input logic [AluWidth-1:0] a,
                                                     input logic [AluWidth-1:0] b,
                                                     input alu_op_e             op);
        logic [ShAmtWidth-1:0] sh;
        logic [AluWidth-1:0]   res;
        sh = b[ShAmtWidth-1:0];
        case (op)
            AluAdd:  res = a + b;
            AluSub:  res = a - b;
            AluAnd:  res = a & b;
            AluOr:   res = a | b;
            AluXor:  res = a ^ b;
            AluSll:  res = a << sh;
            AluSrl:  res = a >> sh;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; on a tie the requester not granted last wins.
module alu_arbiter_rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        unique case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters: accept, execute for one
// cycle, then hold the registered result until the owner takes it.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned Width = AluWidth
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    input  logic             req1_valid_i,
    output logic             req0_ready_o,
    output logic             req1_ready_o,
    input  logic [Width-1:0] req0_a_i,
    input  logic [Width-1:0] req0_b_i,
    input  logic [Width-1:0] req1_a_i,
    input  logic [Width-1:0] req1_b_i,
    input  logic [2:0]       req0_op_i,
    input  logic [2:0]       req1_op_i,
    output logic             resp0_valid_o,
    output logic             resp1_valid_o,
    input  logic             resp0_ready_i,
    input  logic             resp1_ready_i,
    output logic [Width-1:0] resp_result_o,
    output logic             resp_zero_o,
    output logic             busy_o
);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [Width-1:0] a_q, a_d, b_q, b_d;
    alu_op_e          op_q, op_d;
    logic [Width-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             busy_q;

    logic [1:0]       req_valid;
    logic [1:0]       grant;
    logic [1:0]       req_ready;
    logic [1:0]       resp_ready;
    logic [Width-1:0] alu_result;

    assign req_valid  = {req1_valid_i, req0_valid_i};
    assign resp_ready = {resp1_ready_i, resp0_ready_i};

    alu_arbiter_rr_arb2 u_rr_arb2 (
        .valid_i      (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    assign alu_result = alu_eval(a_q, b_q, op_q);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        result_d     = result_q;
        zero_d       = zero_q;
        req_ready    = 2'b00;

        unique case (state_q)
            StIdle: begin
                // Ready is withheld during the reset cycle.
                if (!rst_i) begin
                    req_ready = grant;
                end
                if (|(req_valid & req_ready)) begin
                    owner_d      = grant[1];
                    last_grant_d = grant[1];
                    a_d          = grant[1] ? req1_a_i : req0_a_i;
                    b_d          = grant[1] ? req1_b_i : req0_b_i;
                    op_d         = alu_op_e'(grant[1] ? req1_op_i : req0_op_i);
                    state_d      = StExec;
                end
            end
            StExec: begin
                if (op_q == AluRsvd) begin
                    result_d = '0;
                    zero_d   = 1'b1;
                end else begin
                    result_d = alu_result;
                    zero_d   = (alu_result == '0);
                end
                state_d = StResp;
            end
            StResp: begin
                if (resp_ready[owner_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= AluAdd;
            result_q     <= '0;
            zero_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            busy_q       <= (state_d != StIdle);
        end
    end

    assign req0_ready_o  = req_ready[0];
    assign req1_ready_o  = req_ready[1];
    assign resp0_valid_o = (state_q == StResp) && !owner_q;
    assign resp1_valid_o = (state_q == StResp) && owner_q;
    assign resp_result_o = result_q;
    assign resp_zero_o   = zero_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: scoreboard of expected responses filled on
// request accept and drained on response handshake, plus directed timing checks.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic [31:0] resp_result;
    logic        resp_zero;
    logic        busy;

    alu_arbiter #(.Width(32)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req0_valid_i  (req0_valid),
        .req1_valid_i  (req1_valid),
        .req0_ready_o  (req0_ready),
        .req1_ready_o  (req1_ready),
        .req0_a_i      (req0_a),
        .req0_b_i      (req0_b),
        .req1_a_i      (req1_a),
        .req1_b_i      (req1_b),
        .req0_op_i     (req0_op),
        .req1_op_i     (req1_op),
        .resp0_valid_o (resp0_valid),
        .resp1_valid_o (resp1_valid),
        .resp0_ready_i (resp0_ready),
        .resp1_ready_i (resp1_ready),
        .resp_result_o (resp_result),
        .resp_zero_o   (resp_zero),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        owner;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    exp_t        sb[$];
    int          acc_log[$];
    int          acc_cyc_log[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_resp   = 0;
    int          cyc      = 0;
    int          acc_cyc  = 0;
    int          resp_cyc = 0;
    logic [31:0] last_result;
    logic        last_zero;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd6:    return a << b[4:0];
            3'd7:    return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic exp_t make_exp(input logic owner, input logic [31:0] a,
                                      input logic [31:0] b, input logic [2:0] op);
        exp_t e;
        e.owner = owner;
        e.res   = model(a, b, op);
        e.zero  = (e.res == 32'd0);
        return e;
    endfunction

    // Inputs only change #1 after posedge, so negedge values are what the next edge sees.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (req0_valid && req0_ready) begin
                sb.push_back(make_exp(1'b0, req0_a, req0_b, req0_op));
                acc_log.push_back(0);
                acc_cyc_log.push_back(cyc + 1);
                acc_cyc = cyc + 1;
            end
            if (req1_valid && req1_ready) begin
                sb.push_back(make_exp(1'b1, req1_a, req1_b, req1_op));
                acc_log.push_back(1);
                acc_cyc_log.push_back(cyc + 1);
                acc_cyc = cyc + 1;
            end
            if (resp0_valid || resp1_valid) begin
                if (sb.size() == 0) begin
                    check_val("spurious_resp", 32'({resp1_valid, resp0_valid}), 32'd0);
                end else begin
                    check_val("resp_owner", 32'({resp1_valid, resp0_valid}),
                              sb[0].owner ? 32'd2 : 32'd1);
                    if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
                        check_val("resp_result", resp_result, sb[0].res);
                        check_val("resp_zero", 32'(resp_zero), 32'(sb[0].zero));
                        last_result = resp_result;
                        last_zero   = resp_zero;
                        void'(sb.pop_front());
                        n_resp++;
                        resp_cyc = cyc + 1;
                    end
                end
            end
        end
    end

    task automatic send(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        if (id == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = (id == 0) ? req0_ready : req1_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check_val("accept", 32'(acc), 32'd1);
        if (id == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("drain", 32'(n < 50), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    logic [31:0] bnd_a  [4] = '{32'hFFFF_FFFF, 32'd4, 32'd5, 32'd7};
    logic [31:0] bnd_b  [4] = '{32'd1, 32'd2, 32'd3, 32'd7};
    logic [2:0]  bnd_op [4] = '{3'b000, 3'b111, 3'b100, 3'b101};
    logic [31:0] bnd_res[4] = '{32'd0, 32'd1, 32'd6, 32'd0};
    logic        bnd_z  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int n_before;
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_op = '0; req1_op = '0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;

        // Reset state, with a request pending to show ready stays low.
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val("rst_req0_ready", 32'(req0_ready), 32'd0);
        check_val("rst_req1_ready", 32'(req1_ready), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_resp_valid", 32'({resp1_valid, resp0_valid}), 32'd0);
        check_val("rst_result", resp_result, 32'd0);
        check_val("rst_zero", 32'(resp_zero), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req0_valid = 1'b0;

        // Single request and latency.
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        send(0, 32'd5, 32'd10, 3'b000);
        check_val("lat_busy_after_accept", 32'(busy), 32'd1);
        check_val("lat_resp0_early", 32'(resp0_valid), 32'd0);
        @(posedge clk);
        #1;
        check_val("lat_resp0_valid", 32'(resp0_valid), 32'd1);
        check_val("lat_resp1_valid", 32'(resp1_valid), 32'd0);
        check_val("single_result", resp_result, 32'd15);
        wait_idle();

        // Tie and round-robin from a fresh reset.
        do_reset();
        acc_log.delete();
        acc_cyc_log.delete();
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd5; req0_op = 3'b001;
        req1_valid = 1'b1; req1_a = 32'd5;  req1_b = 32'd3; req1_op = 3'b010;
        repeat (12) @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();
        check_val("rr_count", 32'(acc_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("rr_grant%0d", i),
                      (acc_log.size() > i) ? 32'(acc_log[i]) : 32'hDEAD, 32'(i % 2));
        end
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("rr_spacing%0d", i),
                      (acc_cyc_log.size() > i + 1) ?
                          32'(acc_cyc_log[i+1] - acc_cyc_log[i]) : 32'hDEAD, 32'd3);
        end

        // Back-pressure on requester 1 while requester 0 waits.
        resp1_ready = 1'b0;
        send(1, 32'd5, 32'd2, 3'b110);
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b000;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("bp_result_hold", resp_result, 32'd20);
            check_val("bp_req0_ready", 32'(req0_ready), 32'd0);
            check_val("bp_resp1_valid", 32'(resp1_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        resp1_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("bp_released", 32'(resp1_valid), 32'd0);
        @(negedge clk);
        check_val("bp_req0_granted", 32'(req0_ready), 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        check_val("bp_accept_gap", 32'(acc_cyc - resp_cyc), 32'd1);
        wait_idle();

        // Boundary ops.
        for (int i = 0; i < 4; i++) begin
            send(0, bnd_a[i], bnd_b[i], bnd_op[i]);
            wait_idle();
            check_val($sformatf("bnd_result%0d", i), last_result, bnd_res[i]);
            check_val($sformatf("bnd_zero%0d", i), 32'(last_zero), 32'(bnd_z[i]));
        end

        // Reset while in EXEC drops the transaction.
        send(0, 32'd1, 32'd2, 3'b000);
        n_before = n_resp;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_resp_valid", 32'({resp1_valid, resp0_valid}), 32'd0);
        check_val("mid_rst_result", resp_result, 32'd0);
        check_val("mid_rst_zero", 32'(resp_zero), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check_val("mid_rst_no_resp", 32'(n_resp - n_before), 32'd0);
        send(0, 32'd2, 32'd3, 3'b000);
        wait_idle();
        check_val("post_rst_result", last_result, 32'd5);
        check_val("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
